// File: rtl/mmd_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mmd_pkg
// Brief   : Shared types and default constants for the multi-modulus divider.
// Revision: 1.0 - initial release
// ============================================================================
package mmd_pkg;

    localparam int MMD_NW      = 6;
    localparam int MMD_CW      = 7;
    localparam int MMD_MIN_DIV = 8;
    localparam int MMD_MAX_DIV = 63;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mmd_state_e;

endpackage : mmd_pkg
`default_nettype wire

// File: rtl/mmd_mod_calc.sv
`default_nettype none
// ============================================================================
// Module  : mmd_mod_calc
// Brief   : Combinational modulus = clamp(N + signed div_ctrl) with clamp flag.
// Revision: 1.0 - initial release
// ============================================================================
module mmd_mod_calc
    import mmd_pkg::*;
#(
    parameter int NW      = MMD_NW,
    parameter int CW      = MMD_CW,
    parameter int MIN_DIV = MMD_MIN_DIV,
    parameter int MAX_DIV = MMD_MAX_DIV
) (
    input  logic [NW-1:0] n_word,
    input  logic [NW-1:0] div_ctrl,
    output logic [CW-1:0] modulus,
    output logic          clamp
);

    localparam logic signed [NW+1:0] C_MIN_RAW = (NW+2)'(MIN_DIV);
    localparam logic signed [NW+1:0] C_MAX_RAW = (NW+2)'(MAX_DIV);
    localparam logic [CW-1:0]        C_MIN_M   = CW'(MIN_DIV);
    localparam logic [CW-1:0]        C_MAX_M   = CW'(MAX_DIV);

    logic signed [NW+1:0] w_raw;

    // Two guard bits cover both the unsigned N range and a negative correction.
    assign w_raw = $signed({2'b00, n_word}) + $signed({{2{div_ctrl[NW-1]}}, div_ctrl});

    always_comb begin
        modulus = CW'(w_raw);
        clamp   = 1'b0;
        if (w_raw < C_MIN_RAW) begin
            modulus = C_MIN_M;
            clamp   = 1'b1;
        end else if (w_raw > C_MAX_RAW) begin
            modulus = C_MAX_M;
            clamp   = 1'b1;
        end
    end

endmodule : mmd_mod_calc
`default_nettype wire

// File: rtl/mmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mmd_ctrl
// Brief   : Multi-modulus divider controller pacing the SDM; optional
//           saturation counter enabled by MMD_SAT_CNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module mmd_ctrl
    import mmd_pkg::*;
#(
    parameter int NW      = MMD_NW,
    parameter int CW      = MMD_CW,
    parameter int MIN_DIV = MMD_MIN_DIV,
    parameter int MAX_DIV = MMD_MAX_DIV
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [NW-1:0] N,
    input  logic [NW-1:0] div_ctrl,
    input  logic          sdm_valid,
    output logic          sdm_ack,
    output logic          div_out,
    output logic [CW-1:0] mod_cur,
    output logic          sat,
    output logic          underrun
`ifdef MMD_SAT_CNT_EN
    ,
    output logic [15:0]   sat_cnt
`endif
);

    localparam logic [CW-1:0] C_ONE   = CW'(1);
    localparam logic [CW-1:0] C_MIN_M = CW'(MIN_DIV);

    mmd_state_e    r_state, w_state_nxt;
    logic [CW-1:0] r_cnt,   w_cnt_nxt;
    logic [CW-1:0] r_mod,   w_mod_nxt;
    logic          r_div,   w_div_nxt;
    logic          r_ack,   w_ack_nxt;
    logic          r_sat,   w_sat_nxt;
    logic          r_und,   w_und_nxt;

    logic [CW-1:0] w_m;
    logic          w_clamp;
    logic [CW-1:0] w_cnt_dec;

    mmd_mod_calc #(
        .NW      (NW),
        .CW      (CW),
        .MIN_DIV (MIN_DIV),
        .MAX_DIV (MAX_DIV)
    ) u_mod_calc (
        .n_word   (N),
        .div_ctrl (div_ctrl),
        .modulus  (w_m),
        .clamp    (w_clamp)
    );

    assign w_cnt_dec = r_cnt - C_ONE;

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_mod   <= C_MIN_M;
            r_div   <= 1'b0;
            r_ack   <= 1'b0;
            r_sat   <= 1'b0;
            r_und   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_mod   <= w_mod_nxt;
            r_div   <= w_div_nxt;
            r_ack   <= w_ack_nxt;
            r_sat   <= w_sat_nxt;
            r_und   <= w_und_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_mod_nxt   = r_mod;
        w_div_nxt   = r_div;
        w_ack_nxt   = 1'b0;
        w_sat_nxt   = 1'b0;
        w_und_nxt   = 1'b0;

        case (r_state)
            IDLE: begin
                w_div_nxt = 1'b0;
                if (sdm_valid) begin
                    w_state_nxt = RUN;
                    w_mod_nxt   = w_m;
                    w_cnt_nxt   = w_m - C_ONE;
                    w_ack_nxt   = 1'b1;
                    w_sat_nxt   = w_clamp;
                    w_div_nxt   = 1'b1;
                end
            end
            RUN: begin
                if (r_cnt == '0) begin
                    w_div_nxt = 1'b1;
                    if (sdm_valid) begin
                        w_mod_nxt = w_m;
                        w_cnt_nxt = w_m - C_ONE;
                        w_ack_nxt = 1'b1;
                        w_sat_nxt = w_clamp;
                    end else begin
                        w_cnt_nxt = r_mod - C_ONE;
                        w_und_nxt = 1'b1;
                    end
                end else begin
                    // Low phase covers the last floor(mod/2) counts of the period.
                    w_cnt_nxt = w_cnt_dec;
                    w_div_nxt = (w_cnt_dec >= (r_mod >> 1));
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_div_nxt   = 1'b0;
            end
        endcase
    end

    assign sdm_ack  = r_ack;
    assign div_out  = r_div;
    assign mod_cur  = r_mod;
    assign sat      = r_sat;
    assign underrun = r_und;

`ifdef MMD_SAT_CNT_EN
    logic [15:0] r_sat_cnt;

    // Counts alongside the sat pulse and sticks at all-ones.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_sat_cnt <= '0;
        end else if (w_sat_nxt && (r_sat_cnt != 16'hFFFF)) begin
            r_sat_cnt <= r_sat_cnt + 16'd1;
        end
    end

    assign sat_cnt = r_sat_cnt;
`endif

endmodule : mmd_ctrl
`default_nettype wire

// File: doc/mmd_ctrl.md
Name: mmd_ctrl

Overview:
- Digital multi-modulus divider controller. Sits directly downstream of the sigma-delta modulator in the fractional-N synthesizer.
- Consumes the integer word N and the signed SDM correction div_ctrl. Divides the VCO-rate clock by M = N + div_ctrl, with a new M each output period.
- Produces the divided clock fed back to the phase detector, plus a request/acknowledge strobe that paces the SDM.

Parameters:
- NW, 6, width of N and div_ctrl.
- CW, 7, width of the modulus/counter path.
- MIN_DIV, 8, smallest legal modulus; smaller sums are clamped up to it.
- MAX_DIV, 63, largest legal modulus; larger sums are clamped down to it.

Ports:
- clk  in  1  divider input clock (VCO-rate).
- rstn  in  1  reset; asynchronous, active-high.
- N  in  NW  unsigned integer divide word.
- div_ctrl  in  NW  signed SDM correction, two's complement.
- sdm_valid  in  1  N/div_ctrl pair is valid.
- sdm_ack  out  1  one-cycle pulse; the pair was consumed on this edge.
- div_out  out  1  divided clock.
- mod_cur  out  CW  modulus of the period in progress.
- sat  out  1  one-cycle pulse; the consumed sum was clamped.
- underrun  out  1  one-cycle pulse; modulus reused because sdm_valid was low at a boundary.

Behaviour:
- Reset (rstn=1, asynchronous):
  - state=IDLE, cnt=0, mod_cur=MIN_DIV.
  - div_out, sdm_ack, sat and underrun all 0.
  - Reset mid-period aborts the period immediately. No partial pulse completes after release.
- Modulus calculation (combinational):
  - raw = zero-extended N + sign-extended div_ctrl, evaluated at NW+2 bits signed.
  - M = clamp(raw, MIN_DIV, MAX_DIV).
  - The clamp flag is set when raw < MIN_DIV or raw > MAX_DIV.
- FSM states: IDLE, RUN.
  - IDLE: div_out=0. On a clk edge with sdm_valid=1: mod_cur<=M, cnt<=M-1, sdm_ack<=1, sat<=clamp flag, div_out<=1, go to RUN.
  - RUN: cnt decrements by 1 each clk. When cnt==0 a boundary occurs on that edge:
    - sdm_valid=1: load the new M as in IDLE. sdm_ack pulses and sat reflects the new sum.
    - sdm_valid=0: cnt<=mod_cur-1, mod_cur unchanged, underrun pulses, sdm_ack stays 0.
    - div_out<=1 in both cases.
- div_out timing:
  - Registered output. High for the first ceil(mod_cur/2) clk cycles of a period, low for the remaining floor(mod_cur/2).
  - Equivalently, div_out goes low on the edge where cnt transitions to floor(mod_cur/2)-1.
  - The period is exactly mod_cur clk cycles. Rising edges coincide with boundary edges.
- Handshake:
  - A transfer occurs only when sdm_valid=1 on a boundary edge.
  - sdm_ack goes high the cycle after that edge and lasts exactly 1 cycle. The SDM advances its state on sdm_ack.
  - sdm_valid may stay high continuously. It is never sampled between boundaries.
- Odd modulus example: M=33 gives high for 17 cycles, low for 16.
- Minimum modulus: M=MIN_DIV=8 gives high 4, low 4.
- N and div_ctrl are only required to be stable on boundary edges.

Optional Feature:
- Macro: MMD_SAT_CNT_EN.
- Defined: adds output sat_cnt (16 bits).
  - Increments on every sat pulse and saturates at 16'hFFFF; it never wraps.
  - Reset to 0 by rstn.
- Undefined: no sat_cnt port and no counter logic. All other behaviour is identical.

Decomposition:
- Shared package mmd_pkg holds:
  - State enum {IDLE, RUN}.
  - Default constants MMD_MIN_DIV=8, MMD_MAX_DIV=63.
  - Width constants MMD_NW=6, MMD_CW=7.
- One natural sub-module: mmd_mod_calc, the combinational sum + clamp producing M and the clamp flag. It is reused by the synthesizer-level checker.
- FSM, counter and output registers stay in mmd_ctrl.

Test Plan:
- N=30, div_ctrl=0, sdm_valid=1 constant -> div_out period 30 clk (high 15, low 15); sdm_ack once per period; mod_cur=30.
- N=30, div_ctrl alternating +3/-4 per ack -> periods 33 (high 17/low 16) then 26 (13/13), repeating; no sat, no underrun.
- N=5, div_ctrl=-4 -> M clamped to 8, sat pulses on the load edge; N=63, div_ctrl=+7 -> M=63, sat pulses.
- N=30, div_ctrl=0, sdm_valid dropped for one boundary -> period stays 30, underrun pulses once, no sdm_ack at that boundary; resumes normally when valid returns.
- rstn asserted at cnt=12 within an M=40 period -> all outputs 0 immediately, state IDLE; after release the first rising edge of div_out occurs on the first edge with sdm_valid=1.
- With MMD_SAT_CNT_EN: 70000 consecutive clamped loads -> sat_cnt holds at 16'hFFFF.
